chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_mux.sv | 75 +++++++
 tb/tb_chan_scan_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// Channel scan multiplexer: manual channel load or timed auto-scan over CHANNELS lanes,
// with registered sample output tagged by its source channel.
module chan_scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2,
    parameter int DWELL    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      load,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          dout,
    output logic [SELW-1:0]           dch,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      wrap,
    output logic                      err
);

    localparam logic [SELW:0]   NUM_CH   = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
    localparam logic [7:0]      CNT_LAST = 8'(DWELL - 1);

    logic [7:0]       cnt;
    logic [WIDTH-1:0] cur_data;
    logic             sel_ok;
    logic             advance;

    always_comb begin
        cur_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (ch == SELW'(k)) cur_data = din[k*WIDTH +: WIDTH];
        end
    end

    assign sel_ok  = {1'b0, sel} < NUM_CH;
    assign advance = mode && !hold && !load && (cnt == CNT_LAST);

    // Manual mode pins cnt at 0, so both mode transitions naturally restart the dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch    <= '0;
            cnt   <= '0;
            dout  <= '0;
            dch   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            dout  <= cur_data;
            dch   <= ch;
            valid <= 1'b1;
            wrap  <= advance && (ch == LAST_CH);
            err   <= load && !sel_ok;
            if (load) begin
                cnt <= '0;
                if (sel_ok) ch <= sel;
            end else if (!mode) begin
                cnt <= '0;
            end else if (!hold) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed self-checking bench for chan_scan_mux: default 4-channel instance plus a
// 5-channel instance for out-of-range select handling.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] din_a;
    logic [1:0]  sel_a;
    logic        load_a, mode_a, hold_a;
    logic [3:0]  dout_a;
    logic [1:0]  dch_a, ch_a;
    logic        valid_a, wrap_a, err_a;

    logic [19:0] din_b;
    logic [2:0]  sel_b;
    logic        load_b, mode_b, hold_b;
    logic [3:0]  dout_b;
    logic [2:0]  dch_b, ch_b;
    logic        valid_b, wrap_b, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(4), .CHANNELS(4), .SELW(2), .DWELL(3)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .load(load_a),
        .mode(mode_a), .hold(hold_a), .dout(dout_a), .dch(dch_a), .ch(ch_a),
        .valid(valid_a), .wrap(wrap_a), .err(err_a)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(5), .SELW(3), .DWELL(3)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .load(load_b),
        .mode(mode_b), .hold(hold_b), .dout(dout_b), .dch(dch_b), .ch(ch_b),
        .valid(valid_b), .wrap(wrap_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " ch"},    32'(ch_a),    32'd0);
        check({tag, " dout"},  32'(dout_a),  32'd0);
        check({tag, " dch"},   32'(dch_a),   32'd0);
        check({tag, " valid"}, 32'(valid_a), 32'd0);
        check({tag, " wrap"},  32'(wrap_a),  32'd0);
        check({tag, " err"},   32'(err_a),   32'd0);
    endtask

    initial begin
        din_a = 16'h0101; sel_a = '0; load_a = 0; mode_a = 0; hold_a = 0;
        din_b = 20'h98765; sel_b = '0; load_b = 0; mode_b = 0; hold_b = 0;

        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        check_a_zero("reset_async");
        check("reset_b_valid", 32'(valid_b), 32'd0);

        // inputs during reset are ignored
        load_a = 1; sel_a = 2'd3; mode_a = 1;
        tick();
        check("reset_hold_ch", 32'(ch_a), 32'd0);
        check("reset_hold_valid", 32'(valid_a), 32'd0);
        rst = 1'b0; load_a = 0; sel_a = '0; mode_a = 0;
        check("post_release_valid", 32'(valid_a), 32'd0);
        tick();
        check("first_valid", 32'(valid_a), 32'd1);
        check("first_dch", 32'(dch_a), 32'd0);
        check("first_dout", 32'(dout_a), 32'd1);

        // manual loads, lanes ch3..ch0 = 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            load_a = 1; sel_a = 2'(k);
            tick();
            load_a = 0;
            check("man_ch_load", 32'(ch_a), 32'(k));
            tick();
            check("man_ch", 32'(ch_a), 32'(k));
            check("man_dch", 32'(dch_a), 32'(k));
            check("man_dout", 32'(dout_a), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("man_wrap", 32'(wrap_a), 32'd0);
            check("man_err", 32'(err_a), 32'd0);
        end

        // auto scan from ch0: lanes ch3..ch0 = D,C,B,A
        din_a = 16'hDCBA;
        mode_a = 1; load_a = 1; sel_a = 2'd0;
        tick();
        load_a = 0;
        check("scan_start_ch", 32'(ch_a), 32'd0);
        check("scan_start_wrap", 32'(wrap_a), 32'd0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("scan_ch", 32'(ch_a), 32'((i / 3) % 4));
            check("scan_wrap", 32'(wrap_a), (i == 12 || i == 24) ? 32'd1 : 32'd0);
            check("scan_dch", 32'(dch_a), 32'(((i - 1) / 3) % 4));
            check("scan_dout", 32'(dout_a), 32'(10 + ((i - 1) / 3) % 4));
        end

        // hold for 5 cycles at cnt=1 on ch0
        tick();
        hold_a = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ch", 32'(ch_a), 32'd0);
        end
        hold_a = 0;
        tick();
        check("hold_release_ch", 32'(ch_a), 32'd0);
        tick();
        check("hold_advance_ch", 32'(ch_a), 32'd1);

        // run to ch3 with cnt=2, then load on the would-be wrap edge
        repeat (8) tick();
        check("prewrap_ch", 32'(ch_a), 32'd3);
        load_a = 1; sel_a = 2'd2;
        tick();
        load_a = 0;
        check("loadwrap_ch", 32'(ch_a), 32'd2);
        check("loadwrap_wrap", 32'(wrap_a), 32'd0);
        tick();
        tick();
        check("loadwrap_dwell_ch", 32'(ch_a), 32'd2);
        check("loadwrap_dwell_wrap", 32'(wrap_a), 32'd0);
        tick();
        check("loadwrap_adv_ch", 32'(ch_a), 32'd3);

        // reset between edges with ch=2, cnt=1
        load_a = 1; sel_a = 2'd2;
        tick();
        load_a = 0;
        tick();
        check("midscan_ch", 32'(ch_a), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_a_zero("reset_mid");
        load_a = 1; sel_a = 2'd3;
        tick();
        check("reset_mid_hold_ch", 32'(ch_a), 32'd0);
        rst = 1'b0; load_a = 0; mode_a = 0;
        check("reset_mid_valid0", 32'(valid_a), 32'd0);
        tick();
        check("reset_mid_valid1", 32'(valid_a), 32'd1);
        check("reset_mid_dch", 32'(dch_a), 32'd0);
        check("reset_mid_dout", 32'(dout_a), 32'hA);

        // 5-channel instance: out-of-range select rejected
        load_b = 1; sel_b = 3'd2;
        tick();
        check("b_load2_ch", 32'(ch_b), 32'd2);
        check("b_load2_err", 32'(err_b), 32'd0);
        sel_b = 3'd5;
        tick();
        load_b = 0;
        check("b_sel5_ch", 32'(ch_b), 32'd2);
        check("b_sel5_err", 32'(err_b), 32'd1);
        tick();
        check("b_sel5_err_clear", 32'(err_b), 32'd0);
        check("b_sel5_ch_after", 32'(ch_b), 32'd2);
        load_b = 1; sel_b = 3'd7;
        tick();
        load_b = 0;
        check("b_sel7_err", 32'(err_b), 32'd1);
        load_b = 1; sel_b = 3'd4;
        tick();
        load_b = 0;
        check("b_sel4_ch", 32'(ch_b), 32'd4);
        check("b_sel4_err", 32'(err_b), 32'd0);
        tick();
        check("b_sel4_dch", 32'(dch_b), 32'd4);
        check("b_sel4_dout", 32'(dout_b), 32'h9);
        check("b_wrap", 32'(wrap_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
